// File: rtl/decoder_sched.sv
// decoder_sched -- job sequencer for a convolutional encode/Viterbi decode
// datapath. One job is accepted from IDLE and walked through its stages. Each
// stage enable, the step counter and the status pulses come straight from
// flops. No input reaches an output combinationally.
//
// Ports
//   clk, rst          : clock, asynchronous active-low reset
//   i_start           : start request (sampled in IDLE only)
//   i_abort           : synchronous cancel; forces IDLE on the next edge
//   i_mode_sel        : 0 = encode, 1 = decode
//   i_code_rate       : code-rate select, latched at acceptance
//   i_constr_len      : constraint-length code, 2'b11 reserved (rejected)
//   o_busy            : job in progress (state != IDLE)
//   o_en_ce/s/bm/acs/td/t : datapath stage enables
//   o_step            : step counter value (0 outside RUN/TRACE/ENC)
//   o_code_rate, o_constr_len : latched configuration
//   o_done            : one-cycle completion pulse
//   o_err             : one-cycle rejection pulse
module decoder_sched #(
    parameter int FRAME_LEN = 8,
    parameter int TB_LEN    = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_start,
    input  logic                           i_abort,
    input  logic                           i_mode_sel,
    input  logic                           i_code_rate,
    input  logic [1:0]                     i_constr_len,
    output logic                           o_busy,
    output logic                           o_en_ce,
    output logic                           o_en_s,
    output logic                           o_en_bm,
    output logic                           o_en_acs,
    output logic                           o_en_td,
    output logic                           o_en_t,
    output logic [$clog2(FRAME_LEN+2)-1:0] o_step,
    output logic                           o_code_rate,
    output logic [1:0]                     o_constr_len,
    output logic                           o_done,
    output logic                           o_err
);

    localparam int SW = $clog2(FRAME_LEN + 2);
    localparam int TW = $clog2(TB_LEN + 1);
    // The internal counter must also span the traceback length. o_step shows
    // its low SW bits, which cover the whole traceback whenever
    // TB_LEN <= FRAME_LEN+2.
    localparam int CW = (SW > TW) ? SW : TW;

    localparam logic [CW-1:0] RUN_LAST = CW'(FRAME_LEN + 1);
    localparam logic [CW-1:0] ENC_LAST = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] TB_LAST  = CW'(TB_LEN - 1);
    localparam logic [CW-1:0] FL_C     = CW'(FRAME_LEN);

    typedef enum logic [2:0] {
        IDLE, LOAD, SLICE, RUN, TRACE, ENC, DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mode_q, mode_d;
    logic            cr_q, cr_d;
    logic [1:0]      cl_q, cl_d;

    logic            busy_q, busy_d;
    logic            en_ce_q, en_ce_d;
    logic            en_s_q, en_s_d;
    logic            en_bm_q, en_bm_d;
    logic            en_acs_q, en_acs_d;
    logic            en_td_q, en_td_d;
    logic            en_t_q, en_t_d;
    logic [SW-1:0]   step_q, step_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    // Next state, then every output is computed from that next state. The
    // output flops therefore line up with the state register.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        mode_d  = mode_q;
        cr_d    = cr_q;
        cl_d    = cl_q;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_start && !i_abort) begin
                    if (i_constr_len != 2'b11) begin
                        state_d = LOAD;
                        mode_d  = i_mode_sel;
                        cr_d    = i_code_rate;
                        cl_d    = i_constr_len;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD:  state_d = mode_q ? SLICE : ENC;
            SLICE: state_d = RUN;
            RUN: begin
                if (cnt_q == RUN_LAST) state_d = TRACE;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            TRACE: begin
                if (cnt_q == TB_LAST) state_d = DONE;
                else                  cnt_d   = cnt_q + 1'b1;
            end
            ENC: begin
                if (cnt_q == ENC_LAST) state_d = DONE;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && i_abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end

        busy_d   = (state_d != IDLE);
        en_ce_d  = (state_d == LOAD) || (state_d == ENC);
        en_s_d   = (state_d == SLICE);
        // The bm, acs and td stages each trail the previous one by one cycle.
        en_bm_d  = (state_d == RUN) && (cnt_d < FL_C);
        en_acs_d = (state_d == RUN) && (cnt_d >= CW'(1)) && (cnt_d <= FL_C);
        en_td_d  = (state_d == RUN) && (cnt_d >= CW'(2));
        en_t_d   = (state_d == TRACE);
        step_d   = cnt_d[SW-1:0];
        done_d   = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            cr_q     <= 1'b0;
            cl_q     <= 2'b00;
            busy_q   <= 1'b0;
            en_ce_q  <= 1'b0;
            en_s_q   <= 1'b0;
            en_bm_q  <= 1'b0;
            en_acs_q <= 1'b0;
            en_td_q  <= 1'b0;
            en_t_q   <= 1'b0;
            step_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            cr_q     <= cr_d;
            cl_q     <= cl_d;
            busy_q   <= busy_d;
            en_ce_q  <= en_ce_d;
            en_s_q   <= en_s_d;
            en_bm_q  <= en_bm_d;
            en_acs_q <= en_acs_d;
            en_td_q  <= en_td_d;
            en_t_q   <= en_t_d;
            step_q   <= step_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign o_busy       = busy_q;
    assign o_en_ce      = en_ce_q;
    assign o_en_s       = en_s_q;
    assign o_en_bm      = en_bm_q;
    assign o_en_acs     = en_acs_q;
    assign o_en_td      = en_td_q;
    assign o_en_t       = en_t_q;
    assign o_step       = step_q;
    assign o_code_rate  = cr_q;
    assign o_constr_len = cl_q;
    assign o_done       = done_q;
    assign o_err        = err_q;

endmodule
